// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - fp16 field constants, NaN test and reduction state encoding.
package fp16_pkg;

    localparam int          EXP_MSB   = 14;
    localparam int          EXP_LSB   = 10;
    localparam int          MAN_W     = 10;
    localparam logic [4:0]  EXP_ALL1  = 5'h1F;
    localparam logic [15:0] CANON_NAN = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        EMIT  = 3'd5
    } state_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL1) && (x[MAN_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/fp16_max_reduce_ctrl_if.sv
// rtl/fp16_max_reduce_ctrl_if.sv - input, compare-unit and result streams of the max reducer.
interface fp16_max_reduce_ctrl_if #(
    parameter int IDX_W = 8
);
    logic [15:0]      s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tlast;
    logic             s_axis_tready;
    logic [15:0]      m_axis_cmp_a_tdata;
    logic [15:0]      m_axis_cmp_b_tdata;
    logic             m_axis_cmp_a_tvalid;
    logic             m_axis_cmp_b_tvalid;
    logic [7:0]       s_axis_cmp_result_tdata;
    logic             s_axis_cmp_result_tvalid;
    logic [15:0]      m_axis_max_tdata;
    logic [IDX_W:0]   m_axis_max_tuser;
    logic             m_axis_max_tvalid;
    logic             m_axis_max_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_cmp_a_tdata, m_axis_cmp_b_tdata, m_axis_cmp_a_tvalid, m_axis_cmp_b_tvalid,
        input  s_axis_cmp_result_tdata, s_axis_cmp_result_tvalid,
        output m_axis_max_tdata, m_axis_max_tuser, m_axis_max_tvalid,
        input  m_axis_max_tready
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_cmp_a_tdata, m_axis_cmp_b_tdata, m_axis_cmp_a_tvalid, m_axis_cmp_b_tvalid,
        output s_axis_cmp_result_tdata, s_axis_cmp_result_tvalid,
        input  m_axis_max_tdata, m_axis_max_tuser, m_axis_max_tvalid,
        output m_axis_max_tready
    );

endinterface

// File: rtl/fp16_max_reduce_timer.sv
// rtl/fp16_max_reduce_timer.sv - loadable down-counter flagging a missing response after TIMEOUT cycles.
module fp16_max_reduce_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(TIMEOUT);
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Fires during the last waiting cycle so the caller can leave on the following edge.
    assign o_expire = i_en && (r_count == CW'(1));

endmodule

// File: rtl/fp16_max_reduce_ctrl.sv
// rtl/fp16_max_reduce_ctrl.sv - streaming fp16 max/argmax reducer driving an external A>=B compare unit.
// Optional FP16_NAN_SKIP_EN: NaN elements are counted but never compared or loaded as the maximum.
module fp16_max_reduce_ctrl
    import fp16_pkg::*;
#(
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                   aclk,
    input  logic                   areset,
    fp16_max_reduce_ctrl_if.master bus
);

    localparam int CNT_W = IDX_W + 1;

    state_t            r_state, w_next;
    logic [15:0]       r_max, r_cand;
    logic [IDX_W-1:0]  r_max_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cand_last, r_err;
    logic              w_accept, w_result, w_expire, w_unused;
    logic [IDX_W-1:0]  w_cnt_idx;
    logic [CNT_W-1:0]  w_cnt_inc;
`ifdef FP16_NAN_SKIP_EN
    logic              r_have_max;
    logic              w_nan;
    assign w_nan = is_nan(bus.s_axis_tdata);
`endif

    assign w_accept  = bus.s_axis_tvalid && bus.s_axis_tready;
    assign w_result  = (r_state == WAIT) && bus.s_axis_cmp_result_tvalid;
    assign w_unused  = ^bus.s_axis_cmp_result_tdata[7:1];
    // Counter has one spare bit: once it reaches 2^IDX_W the index saturates and errors are flagged.
    assign w_cnt_idx = r_cnt[IDX_W] ? {IDX_W{1'b1}} : r_cnt[IDX_W-1:0];
    assign w_cnt_inc = r_cnt[IDX_W] ? r_cnt : r_cnt + CNT_W'(1);

    fp16_max_reduce_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .i_clk    (aclk),
        .i_rst    (areset),
        .i_load   (r_state == ISSUE),
        .i_en     (r_state == WAIT),
        .o_expire (w_expire)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = bus.s_axis_tlast ? EMIT : FETCH;
            FETCH: if (w_accept) begin
`ifdef FP16_NAN_SKIP_EN
                if (w_nan || !r_have_max) w_next = bus.s_axis_tlast ? EMIT : FETCH;
                else
`endif
                w_next = ISSUE;
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (w_result)      w_next = r_cand_last ? EMIT : FETCH;
                else if (w_expire) w_next = r_cand_last ? EMIT : DRAIN;
            end
            DRAIN: if (w_accept && bus.s_axis_tlast) w_next = EMIT;
            EMIT:  if (bus.m_axis_max_tready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_max       <= '0;
            r_cand      <= '0;
            r_max_idx   <= '0;
            r_cnt       <= '0;
            r_cand_last <= 1'b0;
            r_err       <= 1'b0;
`ifdef FP16_NAN_SKIP_EN
            r_have_max  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_max     <= bus.s_axis_tdata;
                    r_max_idx <= '0;
                    r_cnt     <= CNT_W'(1);
                    r_err     <= 1'b0;
`ifdef FP16_NAN_SKIP_EN
                    // Holding CANON_NAN while no real maximum exists makes an all-NaN packet emit it.
                    r_have_max <= !w_nan;
                    if (w_nan) begin
                        r_max <= CANON_NAN;
                        r_err <= bus.s_axis_tlast;
                    end
`endif
                end
                FETCH: if (w_accept) begin
`ifdef FP16_NAN_SKIP_EN
                    if (w_nan) begin
                        r_cnt <= w_cnt_inc;
                        if (bus.s_axis_tlast && !r_have_max) r_err <= 1'b1;
                    end else if (!r_have_max) begin
                        r_max      <= bus.s_axis_tdata;
                        r_max_idx  <= w_cnt_idx;
                        r_have_max <= 1'b1;
                        r_cnt      <= w_cnt_inc;
                        if (r_cnt[IDX_W]) r_err <= 1'b1;
                    end else
`endif
                    begin
                        r_cand      <= bus.s_axis_tdata;
                        r_cand_last <= bus.s_axis_tlast;
                    end
                end
                WAIT: begin
                    if (w_result) begin
                        if (!bus.s_axis_cmp_result_tdata[0]) begin
                            r_max     <= r_cand;
                            r_max_idx <= w_cnt_idx;
                        end
                        if (r_cnt[IDX_W]) r_err <= 1'b1;
                        r_cnt <= w_cnt_inc;
                    end else if (w_expire) begin
                        r_err <= 1'b1;
                    end
                end
                EMIT: if (bus.m_axis_max_tready) r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Reset forces tready low immediately, not just from the next edge.
    assign bus.s_axis_tready       = !areset && ((r_state == IDLE) || (r_state == FETCH) || (r_state == DRAIN));
    assign bus.m_axis_cmp_a_tdata  = r_max;
    assign bus.m_axis_cmp_b_tdata  = r_cand;
    assign bus.m_axis_cmp_a_tvalid = (r_state == ISSUE);
    assign bus.m_axis_cmp_b_tvalid = (r_state == ISSUE);
    assign bus.m_axis_max_tdata    = r_max;
    assign bus.m_axis_max_tuser    = {r_err, r_max_idx};
    assign bus.m_axis_max_tvalid   = (r_state == EMIT);

endmodule

// File: tb/tb_fp16_max_reduce_ctrl.sv
// tb/tb_fp16_max_reduce_ctrl.sv - directed and random checks of the fp16 max reducer against an argmax model.
module tb_fp16_max_reduce_ctrl;

    localparam int IDX_W   = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp16_max_reduce_ctrl_if #(.IDX_W(IDX_W)) bus ();

    fp16_max_reduce_ctrl #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .aclk   (clk),
        .areset (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Total order implied by the compare unit: sign-magnitude mapped onto unsigned.
    function automatic logic [15:0] key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    // Compare-unit stand-in: answers cmp_delay cycles after the issue; 0 means never.
    int         cmp_delay  = 1;
    int         cmp_cnt    = 0;
    int         cmp_issues = 0;
    logic       cmp_pend, cmp_res;
    logic [6:0] cmp_junk = 7'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_pend <= 1'b0;
            cmp_cnt  <= 0;
            cmp_res  <= 1'b0;
        end else begin
            cmp_junk <= 7'($urandom);
            if (bus.m_axis_cmp_a_tvalid && bus.m_axis_cmp_b_tvalid) begin
                cmp_pend   <= 1'b1;
                cmp_cnt    <= 1;
                cmp_res    <= key(bus.m_axis_cmp_a_tdata) >= key(bus.m_axis_cmp_b_tdata);
                cmp_issues <= cmp_issues + 1;
            end else if (cmp_pend) begin
                cmp_cnt <= cmp_cnt + 1;
                if (cmp_cnt >= cmp_delay) cmp_pend <= 1'b0;
            end
        end
    end

    assign bus.s_axis_cmp_result_tvalid = cmp_pend && (cmp_delay != 0) && (cmp_cnt == cmp_delay);
    assign bus.s_axis_cmp_result_tdata  = {cmp_junk, cmp_res};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [IDX_W:0] ref_max(input logic [15:0] p[$], output logic [15:0] d);
        int best = 0;
        logic [IDX_W-1:0] idx;
        for (int i = 1; i < p.size(); i++)
            if (key(p[i]) > key(p[best])) best = i;
        d   = p[best];
        idx = (best >= (1 << IDX_W)) ? {IDX_W{1'b1}} : IDX_W'(best);
        return {p.size() > (1 << IDX_W), idx};
    endfunction

    // Entered and left at a negedge; n is the number of cycles tready stayed low.
    task automatic send_elem(input logic [15:0] d, input logic last, output int n);
        n = 0;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        while (!bus.s_axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_bound", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] p[$], input bit gaps);
        int n;
        for (int i = 0; i < p.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            send_elem(p[i], i == p.size() - 1, n);
        end
    endtask

    task automatic recv_check(input string tag, input logic [15:0] d, input logic [IDX_W:0] user,
                              output int waited);
        waited = 0;
        while (!bus.m_axis_max_tvalid && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(bus.m_axis_max_tvalid), 32'd1);
        chk({tag, "_tdata"}, 32'(bus.m_axis_max_tdata), 32'(d));
        chk({tag, "_tuser"}, 32'(bus.m_axis_max_tuser), 32'(user));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop"}, 32'(bus.m_axis_max_tvalid), 32'd0);
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] p[$], input bit gaps, output int waited);
        logic [15:0]    d;
        logic [IDX_W:0] u;
        u = ref_max(p, d);
        send_pkt(p, gaps);
        recv_check(tag, d, u, waited);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_tready"}, 32'(bus.s_axis_tready), 32'd0);
        chk({tag, "_a_tvalid"}, 32'(bus.m_axis_cmp_a_tvalid), 32'd0);
        chk({tag, "_b_tvalid"}, 32'(bus.m_axis_cmp_b_tvalid), 32'd0);
        chk({tag, "_a_tdata"},  32'(bus.m_axis_cmp_a_tdata), 32'd0);
        chk({tag, "_b_tdata"},  32'(bus.m_axis_cmp_b_tdata), 32'd0);
        chk({tag, "_m_tvalid"}, 32'(bus.m_axis_max_tvalid), 32'd0);
        chk({tag, "_m_tdata"},  32'(bus.m_axis_max_tdata), 32'd0);
        chk({tag, "_m_tuser"},  32'(bus.m_axis_max_tuser), 32'd0);
    endtask

    initial begin
        logic [15:0] p[$];
        int          w, n, issues0;

        bus.s_axis_tdata      = '0;
        bus.s_axis_tvalid     = 1'b0;
        bus.s_axis_tlast      = 1'b0;
        bus.m_axis_max_tready = 1'b1;

        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", 32'(bus.s_axis_tready), 32'd1);

        issues0 = cmp_issues;
        p = '{16'h3C00};
        run_pkt("single", p, 1'b0, w);
        chk("single_no_cmp", 32'(cmp_issues - issues0), 32'd0);

        p = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800};
        run_pkt("order", p, 1'b0, w);
        chk("order_latency", 32'(w), 32'd2);

        p = '{16'h8000, 16'h0000, 16'h0000};
        run_pkt("zeros", p, 1'b0, w);
        p = '{16'h4000, 16'h4000};
        run_pkt("tie", p, 1'b0, w);

        bus.m_axis_max_tready = 1'b0;
        p = '{16'h4200};
        send_pkt(p, 1'b0);
        n = 0;
        while (!bus.m_axis_max_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.s_axis_tdata  = 16'h5555;
        bus.s_axis_tlast  = 1'b1;
        bus.s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",    32'(bus.m_axis_max_tvalid), 32'd1);
            chk("bp_tdata",    32'(bus.m_axis_max_tdata), 32'h4200);
            chk("bp_tuser",    32'(bus.m_axis_max_tuser), 32'd0);
            chk("bp_s_tready", 32'(bus.s_axis_tready), 32'd0);
            @(negedge clk);
        end
        bus.s_axis_tvalid     = 1'b0;
        bus.m_axis_max_tready = 1'b1;
        recv_check("bp", 16'h4200, '0, w);

        // Result on the last permitted WAIT cycle is used; one cycle later is a timeout.
        cmp_delay = TIMEOUT;
        p = '{16'h3C00, 16'h4000};
        run_pkt("late_ok", p, 1'b0, w);
        cmp_delay = TIMEOUT + 1;
        send_pkt(p, 1'b0);
        recv_check("late_to", 16'h3C00, {1'b1, 8'd0}, w);

        cmp_delay = 0;
        send_elem(16'h3C00, 1'b0, n);
        send_elem(16'h4000, 1'b0, n);
        send_elem(16'h3800, 1'b1, n);
        chk("to_drain_wait", 32'(n), 32'(TIMEOUT + 1));
        recv_check("timeout", 16'h3C00, {1'b1, 8'd0}, w);
        cmp_delay = 1;
        p = '{16'h3800, 16'h3900};
        run_pkt("err_clear", p, 1'b0, w);

        cmp_delay = 0;
        send_elem(16'h3C00, 1'b0, n);
        send_elem(16'h4000, 1'b0, n);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        cmp_delay = 1;
        @(negedge clk);
        p = '{16'h4400};
        run_pkt("post_reset", p, 1'b0, w);

        for (int k = 0; k < 8; k++) begin
            p = {};
            for (int i = 0; i < $urandom_range(1, 6); i++) p.push_back(16'($urandom));
            cmp_delay = $urandom_range(1, 4);
            run_pkt($sformatf("rand%0d", k), p, 1'b1, w);
        end
        cmp_delay = 1;

        p = {};
        for (int i = 0; i < 255; i++) p.push_back(16'h0000);
        p.push_back(16'h3C00);
        run_pkt("len_max", p, 1'b0, w);
        p.push_front(16'h0000);
        run_pkt("len_over", p, 1'b0, w);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
